// File: rtl/memory_wb_pkg.sv
// Shared Y86-64 encodings for the memory / write-back slice: instruction
// codes, status codes, the "no register" id and the W-register bundle.
package memory_wb_pkg;

    localparam int D_WORD = 64;
    localparam int NIBBLE = 4;

    // Instruction codes
    localparam logic [NIBBLE-1:0] IHALT   = 4'h0;
    localparam logic [NIBBLE-1:0] INOP    = 4'h1;
    localparam logic [NIBBLE-1:0] IRRMOVQ = 4'h2;
    localparam logic [NIBBLE-1:0] IIRMOVQ = 4'h3;
    localparam logic [NIBBLE-1:0] IRMMOVQ = 4'h4;
    localparam logic [NIBBLE-1:0] IMRMOVQ = 4'h5;
    localparam logic [NIBBLE-1:0] IOPQ    = 4'h6;
    localparam logic [NIBBLE-1:0] IJXX    = 4'h7;
    localparam logic [NIBBLE-1:0] ICALL   = 4'h8;
    localparam logic [NIBBLE-1:0] IRET    = 4'h9;
    localparam logic [NIBBLE-1:0] IPUSHQ  = 4'hA;
    localparam logic [NIBBLE-1:0] IPOPQ   = 4'hB;

    // Status codes
    localparam logic [NIBBLE-1:0] SAOK = 4'h1;
    localparam logic [NIBBLE-1:0] SHLT = 4'h2;
    localparam logic [NIBBLE-1:0] SADR = 4'h3;
    localparam logic [NIBBLE-1:0] SINS = 4'h4;

    // Register id meaning "no destination"
    localparam logic [NIBBLE-1:0] RNONE = 4'hF;

    // Contents of the M->W pipeline register
    typedef struct packed {
        logic [NIBBLE-1:0] stat;
        logic [NIBBLE-1:0] icode;
        logic [D_WORD-1:0] valE;
        logic [D_WORD-1:0] valM;
        logic [NIBBLE-1:0] dstE;
        logic [NIBBLE-1:0] dstM;
    } w_bundle_t;

    // Value loaded by a bubble and by reset: an architecturally inert nop
    localparam w_bundle_t W_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        valE:  '0,
        valM:  '0,
        dstE:  RNONE,
        dstM:  RNONE
    };

endpackage

// File: rtl/memory_wb_if.sv
// M-register inputs, pipeline control, same-cycle memory results and the
// registered W bundle exchanged between the memory stage and its neighbours.
interface memory_wb_if;
    logic [3:0]  M_stat_i;
    logic [3:0]  M_icode_i;
    logic [63:0] M_valE_i;
    logic [63:0] M_valA_i;
    logic [3:0]  M_dstE_i;
    logic [3:0]  M_dstM_i;
    logic        W_stall_i;
    logic        W_bubble_i;
    logic [63:0] m_valM_o;
    logic [3:0]  m_stat_o;
    logic [3:0]  W_stat_o;
    logic [3:0]  W_icode_o;
    logic [63:0] W_valE_o;
    logic [63:0] W_valM_o;
    logic [3:0]  W_dstE_o;
    logic [3:0]  W_dstM_o;

    // Pipeline side that feeds the stage and consumes its results
    modport master (
        output M_stat_i, M_icode_i, M_valE_i, M_valA_i, M_dstE_i, M_dstM_i,
        output W_stall_i, W_bubble_i,
        input  m_valM_o, m_stat_o,
        input  W_stat_o, W_icode_o, W_valE_o, W_valM_o, W_dstE_o, W_dstM_o
    );

    // The memory / write-back stage itself
    modport slave (
        input  M_stat_i, M_icode_i, M_valE_i, M_valA_i, M_dstE_i, M_dstM_i,
        input  W_stall_i, W_bubble_i,
        output m_valM_o, m_stat_o,
        output W_stat_o, W_icode_o, W_valE_o, W_valM_o, W_dstE_o, W_dstM_o
    );
endinterface

// File: rtl/memory_wb_data_mem.sv
// Byte-addressed data memory: 8-byte little-endian access at any byte
// address, combinational read, clocked write, and an out-of-range check
// done on the full 64-bit address so huge addresses never alias low memory.
module memory_wb_data_mem #(
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [63:0] i_addr,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic        i_wr_ok,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_rdata,
    output logic        o_err
);
    localparam int          AW        = $clog2(DMEM_BYTES);
    localparam logic [63:0] LAST_ADDR = 64'(DMEM_BYTES - 8);

    logic [7:0]    r_mem [DMEM_BYTES];
    logic [AW-1:0] w_base;

    assign w_base = i_addr[AW-1:0];
    assign o_err  = (i_rd_en || i_wr_en) && (i_addr > LAST_ADDR);

    // Combinational 8-byte read, zero unless a legal read is requested
    always_comb begin
        o_rdata = '0;
        if (i_rd_en && !o_err) begin
            for (int b = 0; b < 8; b++) begin
                o_rdata[8*b +: 8] = r_mem[w_base + AW'(b)];
            end
        end
    end

    // Clocked store; contents are never cleared, and no store lands while reset is held
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (rstn_i && i_wr_en && i_wr_ok && !o_err) begin
            for (int b = 0; b < 8; b++) begin
                r_mem[w_base + AW'(b)] <= i_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_wb.sv
// Y86-64 memory stage plus the M->W pipeline register. Memory read data and
// stage status are produced in the same cycle for decode forwarding; the W
// bundle is registered with stall/bubble control and async active-low reset.
module memory_wb
    import memory_wb_pkg::*;
#(
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    memory_wb_if.slave  bus
);
    logic        w_rd_en;
    logic        w_wr_en;
    logic        w_wr_ok;
    logic        w_err;
    logic [63:0] w_addr;
    logic [63:0] w_rdata;
    logic [3:0]  w_m_stat;
    w_bundle_t   r_w;

    // Address select and read/write enables from the instruction in M
    always_comb begin
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        w_addr  = bus.M_valE_i;
        case (bus.M_icode_i)
            IRMMOVQ, IPUSHQ, ICALL: w_wr_en = 1'b1;
            IMRMOVQ:                w_rd_en = 1'b1;
            IPOPQ, IRET: begin
                w_rd_en = 1'b1;
                w_addr  = bus.M_valA_i;
            end
            default: ;
        endcase
    end

    // A faulting or halted instruction already in W blocks younger stores
    assign w_wr_ok = (r_w.stat == SAOK);

    memory_wb_data_mem #(
        .DMEM_BYTES (DMEM_BYTES)
    ) u_dmem (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .i_addr  (w_addr),
        .i_rd_en (w_rd_en),
        .i_wr_en (w_wr_en),
        .i_wr_ok (w_wr_ok),
        .i_wdata (bus.M_valA_i),
        .o_rdata (w_rdata),
        .o_err   (w_err)
    );

    assign w_m_stat     = w_err ? SADR : bus.M_stat_i;
    assign bus.m_stat_o = w_m_stat;
    assign bus.m_valM_o = w_rdata;

    // W pipeline register: reset/bubble load a nop, stall holds, else capture M results
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_w <= W_BUBBLE;
        end else if (bus.W_stall_i) begin
            r_w <= r_w;
        end else if (bus.W_bubble_i) begin
            r_w <= W_BUBBLE;
        end else begin
            r_w.stat  <= w_m_stat;
            r_w.icode <= bus.M_icode_i;
            r_w.valE  <= bus.M_valE_i;
            r_w.valM  <= w_rdata;
            r_w.dstE  <= bus.M_dstE_i;
            r_w.dstM  <= bus.M_dstM_i;
        end
    end

    assign bus.W_stat_o  = r_w.stat;
    assign bus.W_icode_o = r_w.icode;
    assign bus.W_valE_o  = r_w.valE;
    assign bus.W_valM_o  = r_w.valM;
    assign bus.W_dstE_o  = r_w.dstE;
    assign bus.W_dstM_o  = r_w.dstM;

endmodule

// File: tb/tb_memory_wb.sv
// Scoreboard bench for memory_wb: a driver issues one M-stage instruction per
// cycle and queues the expected combinational outputs and W contents taken
// from a byte-array reference model; a monitor compares on the falling edge.
module tb_memory_wb;
    import memory_wb_pkg::*;

    localparam int DMEM = 1024;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    memory_wb_if bus();

    memory_wb #(.DMEM_BYTES(DMEM)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    typedef struct {
        logic [63:0] valM;
        logic [3:0]  mstat;
        w_bundle_t   w;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_m [DMEM];
    w_bundle_t  w_m;
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic is_rd(input logic [3:0] ic);
        return (ic == IMRMOVQ) || (ic == IPOPQ) || (ic == IRET);
    endfunction

    function automatic logic is_wr(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == IPUSHQ) || (ic == ICALL);
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a);
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[8*b +: 8] = mem_m[int'(a[31:0]) + b];
        return v;
    endfunction

    // Monitor: compare every presented cycle against the queued expectation
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_valM",  bus.m_valM_o,            e.valM);
                chk("m_stat",  64'(bus.m_stat_o),       64'(e.mstat));
                chk("W_stat",  64'(bus.W_stat_o),       64'(e.w.stat));
                chk("W_icode", 64'(bus.W_icode_o),      64'(e.w.icode));
                chk("W_valE",  bus.W_valE_o,            e.w.valE);
                chk("W_valM",  bus.W_valM_o,            e.w.valM);
                chk("W_dstE",  64'(bus.W_dstE_o),       64'(e.w.dstE));
                chk("W_dstM",  64'(bus.W_dstM_o),       64'(e.w.dstM));
            end
        end
    end

    // One instruction per cycle; rst_mid pulls reset low between edges of this cycle
    task automatic step(input logic [3:0] ic, input logic [3:0] st,
                        input logic [63:0] ve, input logic [63:0] va,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic stall, input logic bub, input logic rst_mid);
        exp_t        e;
        logic        rd, wr, err;
        logic [63:0] addr;
        @(posedge clk);
        #1;
        if (!rst_mid) rstn = 1'b1;
        bus.M_icode_i  = ic;
        bus.M_stat_i   = st;
        bus.M_valE_i   = ve;
        bus.M_valA_i   = va;
        bus.M_dstE_i   = de;
        bus.M_dstM_i   = dm;
        bus.W_stall_i  = stall;
        bus.W_bubble_i = bub;
        rd   = is_rd(ic);
        wr   = is_wr(ic);
        addr = ((ic == IPOPQ) || (ic == IRET)) ? va : ve;
        err  = (rd || wr) && (addr > 64'(DMEM - 8));
        e.valM  = (rd && !err) ? model_read(addr) : 64'd0;
        e.mstat = err ? SADR : st;
        if (rst_mid) w_m = W_BUBBLE;
        e.w = w_m;
        exp_q.push_back(e);
        if (rst_mid) begin
            #1;
            rstn = 1'b0;
        end else begin
            if (wr && !err && (w_m.stat == SAOK)) begin
                for (int b = 0; b < 8; b++) mem_m[int'(addr[31:0]) + b] = va[8*b +: 8];
            end
            if (!stall) begin
                if (bub) w_m = W_BUBBLE;
                else w_m = '{stat: e.mstat, icode: ic, valE: ve, valM: e.valM, dstE: de, dstM: dm};
            end
        end
    endtask

    task automatic nop();
        step(INOP, SAOK, 64'd0, 64'd0, RNONE, RNONE, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] a, r;
        logic [3:0]  st;
        bus.M_icode_i  = INOP;
        bus.M_stat_i   = SAOK;
        bus.M_valE_i   = '0;
        bus.M_valA_i   = '0;
        bus.M_dstE_i   = RNONE;
        bus.M_dstM_i   = RNONE;
        bus.W_stall_i  = 1'b0;
        bus.W_bubble_i = 1'b0;
        w_m = W_BUBBLE;
        #2 rstn = 1'b0;
        // Reset held: W shows the bubble
        step(IIRMOVQ, SAOK, 64'h55, 64'd0, 4'd2, RNONE, 1'b0, 1'b0, 1'b1);
        step(IIRMOVQ, SAOK, 64'h66, 64'd0, 4'd2, RNONE, 1'b0, 1'b0, 1'b1);
        // Bring every byte to a known zero
        for (int i = 0; i < DMEM / 8; i++)
            step(IRMMOVQ, SAOK, 64'(i * 8), 64'd0, RNONE, RNONE, 1'b0, 1'b0, 1'b0);
        // Aligned store then same-address load
        step(IRMMOVQ, SAOK, 64'h10, 64'h1122334455667788, RNONE, RNONE, 1'b0, 1'b0, 1'b0);
        step(IMRMOVQ, SAOK, 64'h10, 64'd0, RNONE, 4'd5, 1'b0, 1'b0, 1'b0);
        // Unaligned store and overlapping unaligned load
        step(IRMMOVQ, SAOK, 64'h3, 64'hAABBCCDDEEFF0011, RNONE, RNONE, 1'b0, 1'b0, 1'b0);
        step(IMRMOVQ, SAOK, 64'h4, 64'd0, RNONE, 4'd6, 1'b0, 1'b0, 1'b0);
        // Bounds: last legal address, first illegal, and a near-2^64 store
        step(IRMMOVQ, SAOK, 64'(DMEM - 8), 64'h0102030405060708, RNONE, RNONE, 1'b0, 1'b0, 1'b0);
        step(IMRMOVQ, SAOK, 64'(DMEM - 8), 64'd0, RNONE, 4'd1, 1'b0, 1'b0, 1'b0);
        step(IMRMOVQ, SAOK, 64'(DMEM - 7), 64'd0, RNONE, 4'd1, 1'b0, 1'b0, 1'b0);
        nop();
        step(IRMMOVQ, SAOK, 64'hFFFFFFFFFFFFFFFC, 64'hDEADBEEFDEADBEEF, RNONE, RNONE, 1'b0, 1'b0, 1'b0);
        nop();
        step(IMRMOVQ, SAOK, 64'h0, 64'd0, RNONE, 4'd1, 1'b0, 1'b0, 1'b0);
        step(IPOPQ, SAOK, 64'h8, 64'h0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0);
        // Store suppression behind a faulting instruction in W
        step(IRMMOVQ, SAOK, 64'h20, 64'h5555AAAA5555AAAA, RNONE, RNONE, 1'b0, 1'b0, 1'b0);
        step(INOP, SADR, 64'd0, 64'd0, RNONE, RNONE, 1'b0, 1'b0, 1'b0);
        step(IPUSHQ, SAOK, 64'h20, 64'h0BADF00D0BADF00D, 4'd4, RNONE, 1'b0, 1'b0, 1'b0);
        nop();
        step(IMRMOVQ, SAOK, 64'h20, 64'd0, RNONE, 4'd7, 1'b0, 1'b0, 1'b0);
        // Stall, stall+bubble, bubble
        step(IIRMOVQ, SAOK, 64'h1234, 64'd0, 4'd3, RNONE, 1'b0, 1'b0, 1'b0);
        step(IOPQ, SAOK, 64'h9999, 64'd0, 4'd8, RNONE, 1'b1, 1'b0, 1'b0);
        step(IOPQ, SAOK, 64'h7777, 64'd0, 4'd9, RNONE, 1'b1, 1'b1, 1'b0);
        step(IOPQ, SAOK, 64'h6666, 64'd0, 4'd9, RNONE, 1'b0, 1'b1, 1'b0);
        nop();
        // Reset between edges with valid W contents and a concurrent store
        step(IIRMOVQ, SAOK, 64'hABCD, 64'd0, 4'd3, RNONE, 1'b0, 1'b0, 1'b0);
        step(IRMMOVQ, SAOK, 64'h40, 64'hCAFEBABECAFEBABE, RNONE, RNONE, 1'b0, 1'b0, 1'b1);
        nop();
        step(IMRMOVQ, SAOK, 64'h40, 64'd0, RNONE, 4'd2, 1'b0, 1'b0, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 19))
                0:       a = 64'hFFFFFFFFFFFFFFF0 + 64'($urandom_range(0, 15));
                1:       a = 64'(DMEM - 8 + $urandom_range(0, 15));
                default: a = 64'($urandom_range(0, DMEM - 8));
            endcase
            r  = {$urandom, $urandom};
            st = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 4)) : SAOK;
            if ($urandom_range(0, 1) == 0)
                step(4'($urandom_range(0, 11)), st, a, r, 4'($urandom), 4'($urandom),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b0);
            else
                step(4'($urandom_range(0, 11)), st, r, a, 4'($urandom), 4'($urandom),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b0);
        end
        nop();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
